pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage CPU. It keeps a per-register scoreboard of results not yet forwardable (loads, non-pipelined multiplier) and issues stall, bubble, flush and freeze controls to the IF/ID/EX pipeline registers. Single-cycle ALU results need no stall: the ALU forwarding unit bypasses them from EX/MEM and MEM/WB. The block sits beside the decode stage and drives the enables of the IF, IF/ID and ID/EX registers.

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based hazard controller for the 5-stage pipeline.
// Tracks results that are not yet forwardable (loads, non-pipelined multiplier)
// and drives stall / bubble / flush / freeze controls for IF, IF/ID and ID/EX.
// Optional feature macro: HAZ_PERF_EN builds the saturating stall/flush
// performance counters; without it both perf ports are tied to 0.
module pipe_hazard_ctrl #(
  parameter int NREGS    = 16,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  localparam int IW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [IW-1:0]    id_src_a,
  input  logic [IW-1:0]    id_src_b,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [IW-1:0]    id_dest,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             id_is_mul,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic [NREGS-1:0] pend_mask,
  output logic             mul_busy,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
);

  localparam logic [1:0] LD_SET  = 2'(LOAD_LAT);
  localparam logic [1:0] MUL_SET = 2'(MUL_LAT);

  logic [NREGS-1:0][1:0] cnt, cnt_nxt;
  logic [1:0]            mul_cnt, mul_cnt_nxt;
  logic                  haz;
  logic                  stall_haz;
  logic                  flush_cyc;
  logic                  issue;

  // Decode pending bits and the ID-stage hazard from registered scoreboard state
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pend_mask[i] = (cnt[i] != 2'd0);
    end
    mul_busy = (mul_cnt != 2'd0);
    haz = id_valid & ((id_use_a & pend_mask[id_src_a]) |
                      (id_use_b & pend_mask[id_src_b]) |
                      (id_wr    & pend_mask[id_dest])  |
                      (id_is_mul & mul_busy));
  end

  // Control outputs: freeze beats flush beats hazard stall. rst_n gates them so
  // the pipe sees all-zero controls for the whole time reset is asserted.
  always_comb begin
    flush_cyc = mem_ready & ex_branch_taken;
    stall_haz = mem_ready & ~ex_branch_taken & haz;
    issue     = id_valid & mem_ready & ~ex_branch_taken & ~haz;
    freeze    = rst_n & ~mem_ready;
    stall_if  = rst_n & (~mem_ready | stall_haz);
    stall_id  = rst_n & (~mem_ready | stall_haz);
    bubble_ex = rst_n & stall_haz;
    flush_id  = rst_n & flush_cyc;
    flush_ex  = rst_n & flush_cyc;
  end

  // Next scoreboard state: age everything, then a newly issued producer
  // overrides the decrement on its own destination
  always_comb begin
    cnt_nxt     = cnt;
    mul_cnt_nxt = mul_cnt;
    if (mem_ready) begin
      for (int i = 0; i < NREGS; i++) begin
        if (cnt[i] != 2'd0) begin
          cnt_nxt[i] = cnt[i] - 2'd1;
        end
      end
      if (mul_cnt != 2'd0) begin
        mul_cnt_nxt = mul_cnt - 2'd1;
      end
      if (issue && id_wr && id_is_load) begin
        cnt_nxt[id_dest] = LD_SET;
      end else if (issue && id_wr && id_is_mul) begin
        cnt_nxt[id_dest] = MUL_SET;
      end
      if (issue && id_is_mul) begin
        mul_cnt_nxt = MUL_SET;
      end
    end
  end

  // Scoreboard registers; async reset drops every pending hazard at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mul_cnt <= 2'd0;
    end else begin
      cnt     <= cnt_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Saturating event counters; freeze cycles are neither stalls nor flushes so they hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall_haz && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush_cyc && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, checked
// against a timestamp model (each register/multiplier has a "ready at" time).
module tb_pipe_hazard_ctrl;

  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;

  logic        clk, rst_n;
  logic        id_valid, id_use_a, id_use_b, id_wr, id_is_load, id_is_mul;
  logic [3:0]  id_src_a, id_src_b, id_dest;
  logic        ex_branch_taken, mem_ready;
  logic        stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze, mul_busy;
  logic [15:0] pend_mask;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  pipe_hazard_ctrl #(.NREGS(16), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .freeze(freeze),
    .pend_mask(pend_mask), .mul_busy(mul_busy),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: t advances on every non-frozen edge; a result is pending while ready_at > t
  longint      t;
  longint      ready_at [16];
  longint      mul_free_at;
  int unsigned m_stall, m_flush;

  logic        obs_bubble, obs_stall, obs_flush, obs_busy;
  logic [15:0] obs_pm;
  logic [31:0] obs_ps, obs_pf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int unsigned v);
`ifdef HAZ_PERF_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    t = 0;
    mul_free_at = 0;
    for (int i = 0; i < 16; i++) ready_at[i] = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // One pipeline cycle: drive ID/EX inputs, check outputs against the model, advance.
  task automatic step(input logic v, input logic [3:0] a, input logic ua,
                      input logic [3:0] b, input logic ub, input logic [3:0] d,
                      input logic wr, input logic ld, input logic ml,
                      input logic br, input logic mr);
    logic        haz, busy, bub, fl, iss;
    logic [15:0] pm;
    @(negedge clk);
    id_valid = v; id_src_a = a; id_use_a = ua; id_src_b = b; id_use_b = ub;
    id_dest = d; id_wr = wr; id_is_load = ld; id_is_mul = ml;
    ex_branch_taken = br; mem_ready = mr;
    #1;
    busy = (mul_free_at > t);
    for (int i = 0; i < 16; i++) pm[i] = (ready_at[i] > t);
    haz = v && ((ua && pm[a]) || (ub && pm[b]) || (wr && pm[d]) || (ml && busy));
    fl  = mr && br;
    bub = mr && !br && haz;
    iss = v && mr && !br && !haz;
    check("stall_if",  32'(stall_if),  32'(!mr || bub));
    check("stall_id",  32'(stall_id),  32'(!mr || bub));
    check("bubble_ex", 32'(bubble_ex), 32'(bub));
    check("flush_id",  32'(flush_id),  32'(fl));
    check("flush_ex",  32'(flush_ex),  32'(fl));
    check("freeze",    32'(freeze),    32'(!mr));
    check("pend_mask", 32'(pend_mask), 32'(pm));
    check("mul_busy",  32'(mul_busy),  32'(busy));
    check("perf_stall", perf_stall_cnt, perf_exp(m_stall));
    check("perf_flush", perf_flush_cnt, perf_exp(m_flush));
    obs_bubble = bubble_ex; obs_stall = stall_id; obs_flush = flush_id;
    obs_busy = mul_busy; obs_pm = pend_mask; obs_ps = perf_stall_cnt; obs_pf = perf_flush_cnt;
    @(posedge clk);
    if (mr) begin
      if (iss && wr && ld) ready_at[d] = t + 1 + LOAD_LAT;
      if (iss && wr && ml) ready_at[d] = t + 1 + MUL_LAT;
      if (iss && ml) mul_free_at = t + 1 + MUL_LAT;
      if (bub) m_stall++;
      if (fl) m_flush++;
      t++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic load_r3();
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1);
  endtask
  task automatic dep_r3(input logic br, input logic mr);
    step(1, 3, 1, 1, 1, 5, 1, 0, 0, br, mr);
  endtask
  task automatic mul_to(input logic [3:0] d);
    step(1, 0, 0, 0, 0, d, 1, 0, 1, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze, mul_busy}), 32'd0);
    check({tag, "_pm"}, 32'(pend_mask), 32'd0);
    check({tag, "_perf"}, perf_stall_cnt | perf_flush_cnt, 32'd0);
  endtask

  initial begin
    int n, nb, nbz;
    logic [3:0] ra, rb, rd;
    int cls;
    rst_n = 1'b0;
    id_valid = 0; id_src_a = 0; id_src_b = 0; id_use_a = 0; id_use_b = 0;
    id_dest = 0; id_wr = 0; id_is_load = 0; id_is_mul = 0;
    ex_branch_taken = 0; mem_ready = 0;
    model_reset();
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // load-use
    load_r3();
    dep_r3(0, 1);
    check("lu_stall", 32'(obs_bubble), 32'd1);
    check("lu_pm3", 32'(obs_pm[3]), 32'd1);
    dep_r3(0, 1);
    check("lu_issue", 32'(obs_stall), 32'd0);
    check("lu_pm3_clr", 32'(obs_pm[3]), 32'd0);

    // back-to-back multiplies
    mul_to(2);
    n = 0; nb = 0;
    for (int k = 0; k < 8; k++) begin
      mul_to(4);
      if (!obs_bubble) break;
      n++;
      if (obs_busy) nb++;
    end
    check("mul_stalls", 32'(n), 32'(MUL_LAT));
    check("mul_busy_cyc", 32'(nb), 32'(MUL_LAT));
    check("mul_pm2_clr", 32'({obs_pm[2], obs_busy}), 32'd0);
    repeat (4) idle();

    // freeze stretches the load-use stall
    load_r3();
    n = 0; nbz = 0;
    dep_r3(0, 0); n += int'(obs_stall); nbz += int'(obs_bubble);
    dep_r3(0, 0); n += int'(obs_stall); nbz += int'(obs_bubble);
    for (int k = 0; k < 6; k++) begin
      dep_r3(0, 1);
      if (!obs_stall) break;
      n++;
    end
    check("frz_total_stall", 32'(n), 32'd3);
    check("frz_no_bubble", 32'(nbz), 32'd0);

    // flush while stalled on r3
    load_r3();
    dep_r3(1, 1);
    check("fl_flush", 32'(obs_flush), 32'd1);
    check("fl_nostall", 32'(obs_stall), 32'd0);
    idle();
    check("fl_pm3_clr", 32'(obs_pm[3]), 32'd0);

    // immediate form ignores src_b; ALU WAW stalls
    mul_to(3);
    step(1, 1, 1, 3, 0, 6, 1, 0, 0, 0, 1);
    check("imm_nostall", 32'(obs_stall), 32'd0);
    step(1, 1, 1, 1, 0, 3, 1, 0, 0, 0, 1);
    check("waw_stall", 32'(obs_bubble), 32'd1);
    repeat (4) idle();

    // async reset mid-stall
    load_r3();
    @(negedge clk);
    id_valid = 1; id_src_a = 3; id_use_a = 1; id_src_b = 1; id_use_b = 1;
    id_dest = 5; id_wr = 1; id_is_load = 0; id_is_mul = 0;
    ex_branch_taken = 0; mem_ready = 1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    mem_ready = 0;
    #1;
    check("async_rst_frz", 32'(freeze), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle();
    check("post_rst_pm", 32'(obs_pm), 32'd0);

    // 5 stalls, 2 flushes
    mul_to(2);
    for (int k = 0; k < 8; k++) begin mul_to(4); if (!obs_bubble) break; end
    repeat (2) begin
      load_r3();
      for (int k = 0; k < 4; k++) begin dep_r3(0, 1); if (!obs_bubble) break; end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    check("perf_stall5", obs_ps, perf_exp(5));
    check("perf_flush2", obs_pf, perf_exp(2));

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      ra = 4'($urandom_range(0, 5));
      rb = 4'($urandom_range(0, 5));
      rd = 4'($urandom_range(0, 5));
      cls = int'($urandom_range(0, 3));
      step(($urandom_range(0, 7) != 0), ra, 1'($urandom), rb, 1'($urandom), rd,
           1'($urandom_range(0, 3) != 0), (cls == 0), (cls == 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
